// File: rtl/pi_link_scheduler.sv
// pi_link_scheduler
//   Shares the single 10-bit voltage link to the Raspberry Pi among N_CH
//   sample sources. A round-robin arbiter picks a requester while idle, captures
//   its sample and starts a serializer frame. The voltage and channel tag stay
//   stable for the whole frame, and an idle gap follows before the next grant.
//
// Ports
//   sclk     in   link clock, all state updates on posedge
//   reset    in   asynchronous, active-high reset
//   enable   in   permits new frames (never aborts a frame in flight)
//   req      in   [N_CH]     per-channel request, held until ack
//   data     in   [10*N_CH]  per-channel sample, channel k at [10k+9:10k]
//   ack      out  [N_CH]     one-hot capture pulse, coincident with start
//   start    out  serializer start, one cycle per frame
//   voltage  out  [10]       sample being sent, held until the next capture
//   chan     out  [clog2(N_CH)] channel tag of voltage
//   busy     out  high from start through the end of the gap
module pi_link_scheduler #(
   parameter int N_CH      = 4,
   parameter int FRAME_CYC = 16,
   parameter int GAP_CYC   = 2
) (
   input  logic                    sclk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [N_CH-1:0]         req,
   input  logic [10*N_CH-1:0]      data,
   output logic [N_CH-1:0]         ack,
   output logic                    start,
   output logic [9:0]              voltage,
   output logic [$clog2(N_CH)-1:0] chan,
   output logic                    busy
);
   localparam int CW      = $clog2(N_CH);
   localparam int CNT_MAX = (FRAME_CYC > GAP_CYC) ? FRAME_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_HOLD, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     chan_q, chan_d;
   logic [9:0]        volt_q, volt_d;
   logic [N_CH-1:0]   ack_q, ack_d;
   logic              start_q, start_d;

   // Round-robin search: rotate the request vector so the pointer sits at
   // bit 0, take the lowest set bit, then map the offset back to a channel.
   logic [2*N_CH-1:0] req_rot;
   logic [CW-1:0]     gnt_off;
   logic [CW:0]       gnt_sum;
   logic [CW-1:0]     gnt_idx;
   logic              gnt_vld;
   logic [9:0]        gnt_data;

   assign req_rot = {req, req} >> ptr_q;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_off = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!gnt_vld && req_rot[i]) begin
            gnt_vld = 1'b1;
            gnt_off = CW'(i);
         end
      end
      gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
      if (gnt_sum >= (CW+1)'(N_CH))
         gnt_sum = gnt_sum - (CW+1)'(N_CH);
      gnt_idx  = gnt_sum[CW-1:0];
      gnt_data = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (gnt_idx == CW'(c))
            gnt_data = data[10*c +: 10];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      chan_d  = chan_q;
      volt_d  = volt_q;
      ack_d   = '0;
      start_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable && gnt_vld) begin
               state_d = S_START;
               start_d = 1'b1;
               ack_d   = N_CH'(1) << gnt_idx;
               chan_d  = gnt_idx;
               volt_d  = gnt_data;
               ptr_d   = (gnt_idx == CW'(N_CH-1)) ? '0 : gnt_idx + CW'(1);
            end
         end
         S_START: begin
            // START is the first frame cycle; HOLD covers the remaining ones.
            state_d = S_HOLD;
            cnt_d   = CNT_W'(FRAME_CYC - 2);
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               if (GAP_CYC == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = CNT_W'(GAP_CYC - 1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         chan_q  <= '0;
         volt_q  <= '0;
         ack_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         chan_q  <= chan_d;
         volt_q  <= volt_d;
         ack_q   <= ack_d;
         start_q <= start_d;
      end
   end

   assign ack     = ack_q;
   assign start   = start_q;
   assign voltage = volt_q;
   assign chan    = chan_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_pi_link_scheduler.sv
// Bench for pi_link_scheduler: two instances (default timing, and an 11-cycle
// frame with no gap) are driven by random requesters and compared each cycle
// against a frame-level reference model.
module tb_pi_link_scheduler;
   localparam int N = 4;

   logic              sclk = 1'b0;
   logic              reset;
   logic              enable;
   logic [N-1:0]      req     [2];
   logic [10*N-1:0]   data    [2];
   logic [N-1:0]      ack     [2];
   logic              start   [2];
   logic [9:0]        voltage [2];
   logic [1:0]        chan    [2];
   logic              busy    [2];

   always #5 sclk = ~sclk;

   pi_link_scheduler #(.N_CH(N), .FRAME_CYC(16), .GAP_CYC(2)) u_a (
      .sclk(sclk), .reset(reset), .enable(enable), .req(req[0]), .data(data[0]),
      .ack(ack[0]), .start(start[0]), .voltage(voltage[0]), .chan(chan[0]),
      .busy(busy[0]));

   pi_link_scheduler #(.N_CH(N), .FRAME_CYC(11), .GAP_CYC(0)) u_b (
      .sclk(sclk), .reset(reset), .enable(enable), .req(req[1]), .data(data[1]),
      .ack(ack[1]), .start(start[1]), .voltage(voltage[1]), .chan(chan[1]),
      .busy(busy[1]));

   // Reference model: a frame occupies FRAME_CYC+GAP_CYC busy cycles; a new
   // grant can only be made on an edge where nothing is left of that budget.
   int          frame_len [2] = '{18, 11};
   int          m_left [2];
   int          m_ptr  [2];
   int          m_chan [2];
   logic [9:0]  m_volt [2];
   logic        m_start[2];
   logic [N-1:0] m_ack [2];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_left[k] = 0; m_ptr[k] = 0; m_chan[k] = 0;
      m_volt[k] = '0; m_start[k] = 1'b0; m_ack[k] = '0;
   endtask

   task automatic model_step(input int k);
      bit found;
      m_start[k] = 1'b0;
      m_ack[k]   = '0;
      found      = 1'b0;
      if (m_left[k] > 0) begin
         m_left[k]--;
      end else if (enable && (req[k] != '0)) begin
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr[k] + i) % N;
            if (!found && req[k][c]) begin
               found      = 1'b1;
               m_chan[k]  = c;
               m_volt[k]  = data[k][10*c +: 10];
               m_ack[k]   = N'(1) << c;
               m_start[k] = 1'b1;
               m_ptr[k]   = (c + 1) % N;
               m_left[k]  = frame_len[k];
            end
         end
      end
   endtask

   task automatic check_out(input int k);
      string p;
      p = (k == 0) ? "a" : "b";
      chk({p, "_start"},   32'(start[k]),   32'(m_start[k]));
      chk({p, "_ack"},     32'(ack[k]),     32'(m_ack[k]));
      chk({p, "_busy"},    32'(busy[k]),    32'(m_left[k] > 0));
      chk({p, "_voltage"}, 32'(voltage[k]), 32'(m_volt[k]));
      chk({p, "_chan"},    32'(chan[k]),    32'(m_chan[k]));
   endtask

   // Requesters drop req on ack and sometimes re-request at once with a new
   // sample; in random mode they also raise requests and rarely give up.
   task automatic drive_reqs(input int k, input bit rnd);
      for (int c = 0; c < N; c++) begin
         if (ack[k][c]) begin
            req[k][c] = 1'b0;
            if (!rnd || k == 1 || $urandom_range(0, 1) == 1) begin
               req[k][c] = (!rnd && k == 0) ? 1'b0 : 1'b1;
               data[k][10*c +: 10] = 10'($urandom);
            end
         end else if (rnd && req[k][c]) begin
            if ($urandom_range(0, 199) == 0) req[k][c] = 1'b0;
         end else if (rnd && $urandom_range(0, 3) == 0) begin
            req[k][c] = 1'b1;
            data[k][10*c +: 10] = 10'($urandom);
         end
      end
   endtask

   int busy_cnt = 0;
   int starts_a = 0;
   bit did_reset = 1'b0;
   int rel_cyc = -1;

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req[k]  = '0;
         data[k] = '0;
         model_reset(k);
      end
      #3;
      for (int k = 0; k < 2; k++) check_out(k);

      @(negedge sclk);
      reset  = 1'b0;
      enable = 1'b1;
      req[0] = 4'b0100;
      data[0][29:20] = 10'h2A5;
      req[1] = 4'b0011;
      data[1] = {$urandom, $urandom};

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge sclk);
         if (!reset) for (int k = 0; k < 2; k++) model_step(k);
         #1;
         for (int k = 0; k < 2; k++) check_out(k);
         if (cyc < 30 && busy[0]) busy_cnt++;
         if (cyc < 30 && start[0]) begin
            starts_a++;
            chk("dir_voltage", 32'(voltage[0]), 32'h2A5);
            chk("dir_chan",    32'(chan[0]),    32'd2);
            chk("dir_ack",     32'(ack[0]),     32'b0100);
         end

         @(negedge sclk);
         if (cyc == 30) begin
            chk("dir_busy_len", busy_cnt, 18);
            chk("dir_starts",   starts_a, 1);
         end
         for (int k = 0; k < 2; k++) drive_reqs(k, cyc >= 30);
         if (cyc >= 30 && $urandom_range(0, 24) == 0) enable = ~enable;

         if (cyc == rel_cyc) reset = 1'b0;
         // Asynchronous reset landing in the eighth HOLD cycle of instance a.
         if (!did_reset && cyc > 300 && !reset && m_left[0] == 10) begin
            did_reset = 1'b1;
            rel_cyc   = cyc + 3;
            #2 reset = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) model_reset(k);
            for (int k = 0; k < 2; k++) check_out(k);
         end
      end
      chk("reset_exercised", 32'(did_reset), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
